debounce_bank: RTL
==================

# debounce_bank

Multi-channel, parametrised input debouncer for push-buttons and switches feeding the CPU's I/O front end. Each channel synchronises an asynchronous input, samples it on a shared prescaled tick, and changes its debounced level only after DELAY consecutive samples disagree with it. It emits one-clock rise and fall pulses per channel, and generalises the single-channel, rise-only debouncer to N channels with both edges, a programmable filter length, a programmable sample rate, and reset.

## Interface
- CHANNELS, 4: number of independent input channels (>=1)
- DELAY, 8: consecutive differing samples required to flip a level (>=1)
- PRESCALE, 2: clk cycles per sample tick (>=1; 1 = sample every cycle)
- INIT_LEVEL, 0: reset value of synchronisers and debounced levels (0/1, all channels)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- data  in  CHANNELS  raw asynchronous inputs, one bit per channel
- level  out  CHANNELS  debounced level per channel
- rise  out  CHANNELS  one-clk pulse when level goes 0->1
- fall  out  CHANNELS  one-clk pulse when level goes 1->0
- tick  out  1  sample strobe (debug/observation), high one clk every PRESCALE cycles

## Operation
- Synchroniser: 2-FF chain per channel on clk. sync[i] is data[i] delayed by 2 clk.
- Prescaler: shared counter, width max(1,$clog2(PRESCALE)). Counts 0..PRESCALE-1 and wraps. tick=1 in the cycle the counter equals PRESCALE-1. With PRESCALE=1, tick is constantly 1.
- Per-channel counter cnt, width $clog2(DELAY+1). Updates only on tick cycles:
  - sync==level: cnt<=0 (glitch rejected; partial count discarded).
  - sync!=level and cnt==DELAY-1: level<=sync, cnt<=0, and the matching pulse fires.
  - sync!=level otherwise: cnt<=cnt+1.
- Non-tick cycles: cnt and level hold. rise and fall are 0.
- Pulses are registered. rise[i]/fall[i] are high in exactly the clk cycle in which the new level[i] is first visible, for one clk only. rise and fall of the same channel are never high together.
- Channels are fully independent. Simultaneous events on different channels produce pulses in the same cycle.
- Reset (async assert, sync-clean deassert assumed from the system reset tree):
  - synchronisers and level = INIT_LEVEL
  - cnt = 0, prescaler = 0
  - rise = fall = 0, tick = 0
  - No pulse is ever generated by reset assertion or release. A reset mid-count discards the count.

## Timing
- Latency from a stable data change to the level/pulse cycle is between 2 + (DELAY-1)·PRESCALE + 1 and 2 + DELAY·PRESCALE + 1 clk, depending on tick phase.
- After reset release, the first tick occurs on the PRESCALE-th rising clk edge.
- Minimum stable input width that is guaranteed to be accepted: DELAY·PRESCALE clk.
- Inputs shorter than (DELAY-1)·PRESCALE clk are guaranteed rejected.
- Back-to-back toggles: after a flip, cnt=0, so the opposite transition needs a full DELAY ticks again. Maximum pulse rate per channel is one per DELAY ticks.
- All outputs are registered. No combinational path from data to any output.

## Structure
- Package lite_io_pkg holds the default constants: DEBOUNCE_DELAY=8, DEBOUNCE_PRESCALE=2.
- Sub-module debounce_channel holds the synchroniser, counter, level and pulse registers for one channel. It takes tick as an input and is instantiated CHANNELS times in a generate loop.
- The prescaler lives in the top-level debounce_bank.

## Test plan
Defaults throughout (CHANNELS=4, DELAY=8, PRESCALE=2, INIT_LEVEL=0) unless stated.
- Reset: hold rst_n=0 with data=4'hF.
  - Required during reset: level=0, rise=fall=0.
  - After release with data held: rise=4'hF for exactly one clk, 17–19 clk after release; level=4'hF thereafter.
- Glitch rejection: from level=0, drive data[1]=1 for 12 clk, then 0.
  - Required: rise[1] never asserts, level[1] stays 0.
  - Then hold data[1]=1 for 20 clk. Required: exactly one rise[1].
- Falling edge: from level[2]=1, drive data[2]=0.
  - Required: one fall[2] pulse, level[2]=0, rise[2]=0 throughout.
- Simultaneous channels: in the same cycle drive data[0] 0->1 and data[3] 1->0.
  - Required: rise[0] and fall[3] pulse in the same clk; channels 1 and 2 stay quiet.
- Reset mid-count: raise data[0], assert rst_n after 10 clk, release 3 clk later with data[0] still high.
  - Required: level, rise and fall clear immediately, with no pulse on release.
  - rise[0] occurs only after a full 17–19 clk from release.
- Corner parameters PRESCALE=1, DELAY=1:
  - tick is constantly 1 after reset.
  - A 1-clk data[0] high pulse gives level[0] high 3 clk later, for 1 clk, with rise then fall pulses.

Source files
------------

// File: rtl/lite_io_pkg.sv
// Shared constants for the lightweight I/O front end.
// Default debounce filter length and sample rate.
package lite_io_pkg;
    localparam int DEBOUNCE_DELAY    = 8;
    localparam int DEBOUNCE_PRESCALE = 2;
endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF synchroniser, disagreement counter,
// debounced level and registered rise/fall pulses.
module debounce_channel
    import lite_io_pkg::*;
#(
    parameter int   DELAY      = DEBOUNCE_DELAY,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_data,
    input  logic i_tick,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam int            CW   = $clog2(DELAY + 1);
    localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          w_level_nxt;
    logic          r_rise;
    logic          w_rise_nxt;
    logic          r_fall;
    logic          w_fall_nxt;

    // Two-stage synchroniser; r_sync[1] is the sampled input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{INIT_LEVEL}};
        end else begin
            r_sync <= {r_sync[0], i_data};
        end
    end

    // Filter decision: any agreeing sample discards the partial count
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (i_tick) begin
            if (r_sync[1] == r_level) begin
                w_cnt_nxt = {CW{1'b0}};
            end else if (r_cnt == LAST) begin
                w_cnt_nxt   = {CW{1'b0}};
                w_level_nxt = r_sync[1];
                w_rise_nxt  = r_sync[1];
                w_fall_nxt  = ~r_sync[1];
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter, level and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= {CW{1'b0}};
            r_level <= INIT_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: shared sample-tick prescaler driving
// CHANNELS independent debounce_channel instances.
module debounce_bank
    import lite_io_pkg::*;
#(
    parameter int   CHANNELS   = 4,
    parameter int   DELAY      = DEBOUNCE_DELAY,
    parameter int   PRESCALE   = DEBOUNCE_PRESCALE,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] data,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);
    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pcnt;
    logic [PW-1:0] w_pcnt_nxt;
    logic          r_tick;

    // Prescaler wrap at PRESCALE-1
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        if (r_pcnt == P_LAST) begin
            w_pcnt_nxt = {PW{1'b0}};
        end else begin
            w_pcnt_nxt = r_pcnt + PW'(1);
        end
    end

    // Tick is registered so it is high exactly while the counter sits at PRESCALE-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt <= {PW{1'b0}};
            r_tick <= 1'b0;
        end else begin
            r_pcnt <= w_pcnt_nxt;
            r_tick <= (w_pcnt_nxt == P_LAST);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        debounce_channel #(
            .DELAY      (DELAY),
            .INIT_LEVEL (INIT_LEVEL)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_data  (data[g]),
            .i_tick  (r_tick),
            .o_level (level[g]),
            .o_rise  (rise[g]),
            .o_fall  (fall[g])
        );
    end

    assign tick = r_tick;
endmodule
